operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Register-read stage between decode and execute: drives register-file read addresses,
//  bypasses same-cycle writeback data and tracks pending destination writes in a scoreboard.
//  Stalls on RAW/WAW hazards. Holds one instruction in an output register with
//  valid/ready handshakes on both sides.
//  Register-file writes land at the clock edge and its reads are combinational, hence the bypass.
// PARAMETERS
//  REG_NUMBER     32  architectural registers; register 0 is hardwired zero
//  DATA_WIDTH     32  operand / writeback data width
//  PAYLOAD_WIDTH  64  opaque decode payload carried alongside operands
// PORTS
//  clk            in   1     single clock
//  rst            in   1     reset; asynchronous, active-low
//  inValid        in   1     decode offers an instruction
//  inReady        out  1     stage accepts (capture when inValid && inReady)
//  inRs1Addr/inRs2Addr  in  log2(REG_NUMBER)  source registers
//  inRs1Used/inRs2Used  in  1  source actually read (unused sources never hazard)
//  inRdAddr       in   log2(REG_NUMBER)  destination register
//  inRdWrite      in   1     instruction writes rd
//  inPayload      in   PAYLOAD_WIDTH  passed through unchanged
//  rfRs1Addr/rfRs2Addr  out  log2(REG_NUMBER)  to register-file read ports (= inRs*Addr)
//  rfRs1Data/rfRs2Data  in   DATA_WIDTH        from register-file read ports
//  wbEnable       in   1     writeback this cycle (same signals feed the register file)
//  wbAddr         in   log2(REG_NUMBER)  writeback destination
//  wbData         in   DATA_WIDTH  writeback value
//  outValid       out  1     execute-side instruction valid
//  outReady       in   1     execute accepts (issue when outValid && outReady)
//  outRs1Data/outRs2Data  out  DATA_WIDTH  resolved operands
//  outRdAddr, outRdWrite, outPayload  out  captured copies
//  flush          in   1     kill held instruction and clear scoreboard
// BEHAVIOUR
//  - Reset (rst=0, async): outValid=0, all out data/addr/payload=0, scoreboard all 0.
//    inReady is comb and therefore 0 while hazards exist; no state survives reset mid-operation.
//  - Scoreboard: REG_NUMBER bits, bit 0 is always 0.
//    Set bit rd on issue when outRdWrite && outRdAddr!=0.
//    Clear bit wbAddr on wbEnable && wbAddr!=0. Set wins on the same address in the same cycle.
//  - Pending(r) = sb[r] && !(wbEnable && wbAddr==r), or
//    (outValid && outReady && outRdWrite && outRdAddr==r). r==0 is never pending.
//  - hazard = (inRs1Used && Pending(inRs1Addr)) || (inRs2Used && Pending(inRs2Addr))
//    || (inRdWrite && Pending(inRdAddr)). The last term is WAW.
//  - inReady = !flush && !hazard && (!outValid || outReady). Combinational.
//  - Capture latency is 1 cycle: the accepted instruction has outValid=1 on the next edge.
//  - Operand select per source: addr==0 -> 0; else wbEnable && wbAddr==addr -> wbData;
//    else rfRsNData.
//  - Output register holds its contents stable while outValid && !outReady.
//    It clears outValid on issue with no capture.
//  - flush (sync, priority over everything): next cycle outValid=0 and scoreboard all 0.
//    Capture is blocked that cycle. Caller guarantees no issued writes remain in flight.
//  - wbEnable for a register not pending is legal; it only updates forwarding.
// TESTING
//  1. Reset mid-stream: rst=0 with outValid=1 -> outValid=0, sb=0 immediately, no clk needed.
//  2. RAW stall: issue x5<-.., then read x5 -> inReady=0 until wbEnable(x5,0xDEAD).
//     Same cycle inReady=1; operand=0xDEAD.
//  3. Back-to-back: outReady=1, issue writer x3, next instruction reads x3 same cycle
//     -> inReady=0 (outgoing rd term).
//  4. x0: inRs1Addr=0, wbEnable(x0,0xFFFF) -> operand 0, never stalls; sb[0] stays 0.
//  5. Backpressure: outReady=0 for 3 cycles -> outputs stable, inReady=0.
//     outReady=1 -> issue plus new capture in same cycle.
//  6. flush with outValid=1 and sb[7]=1 -> next cycle outValid=0; a read of x7 accepted at once.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Register-read stage between decode and execute: forwards same-cycle writeback,
// tracks pending destination writes in a scoreboard and stalls on RAW/WAW hazards.
module operand_fetch_stage #(
  parameter int REG_NUMBER    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 64,
  localparam int AW           = $clog2(REG_NUMBER)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [AW-1:0]            inRs1Addr,
  input  logic [AW-1:0]            inRs2Addr,
  input  logic                     inRs1Used,
  input  logic                     inRs2Used,
  input  logic [AW-1:0]            inRdAddr,
  input  logic                     inRdWrite,
  input  logic [PAYLOAD_WIDTH-1:0] inPayload,
  output logic [AW-1:0]            rfRs1Addr,
  output logic [AW-1:0]            rfRs2Addr,
  input  logic [DATA_WIDTH-1:0]    rfRs1Data,
  input  logic [DATA_WIDTH-1:0]    rfRs2Data,
  input  logic                     wbEnable,
  input  logic [AW-1:0]            wbAddr,
  input  logic [DATA_WIDTH-1:0]    wbData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_WIDTH-1:0]    outRs1Data,
  output logic [DATA_WIDTH-1:0]    outRs2Data,
  output logic [AW-1:0]            outRdAddr,
  output logic                     outRdWrite,
  output logic [PAYLOAD_WIDTH-1:0] outPayload,
  input  logic                     flush
);

  localparam logic [AW-1:0]         ZERO_ADDR = {AW{1'b0}};
  localparam logic [REG_NUMBER-1:0] ONE_HOT0  = {{(REG_NUMBER-1){1'b0}}, 1'b1};

  logic [REG_NUMBER-1:0] scoreboard;
  logic [REG_NUMBER-1:0] sb_next;
  logic [REG_NUMBER-1:0] clr_mask;
  logic [REG_NUMBER-1:0] set_mask;
  logic                  issue;
  logic                  issue_write;
  logic                  capture;
  logic                  hazard;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;

  // A register is pending if an older write is outstanding and not landing now,
  // or if the instruction leaving this cycle is about to claim it.
  function automatic logic pending(
    input logic [AW-1:0]         r,
    input logic [REG_NUMBER-1:0] sb,
    input logic                  wb_en,
    input logic [AW-1:0]         wb_a,
    input logic                  iss_wr,
    input logic [AW-1:0]         iss_rd
  );
    pending = (r != ZERO_ADDR) &&
              ((sb[r] && !(wb_en && (wb_a == r))) || (iss_wr && (iss_rd == r)));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [AW-1:0]         addr,
    input logic                  wb_en,
    input logic [AW-1:0]         wb_a,
    input logic [DATA_WIDTH-1:0] wb_d,
    input logic [DATA_WIDTH-1:0] rf_d
  );
    if (addr == ZERO_ADDR) begin
      select_operand = {DATA_WIDTH{1'b0}};
    end else if (wb_en && (wb_a == addr)) begin
      select_operand = wb_d;
    end else begin
      select_operand = rf_d;
    end
  endfunction

  assign rfRs1Addr = inRs1Addr;
  assign rfRs2Addr = inRs2Addr;

  // Handshake and hazard detection.
  always_comb begin
    issue       = outValid && outReady;
    issue_write = issue && outRdWrite;
    hazard = (inRs1Used && pending(inRs1Addr, scoreboard, wbEnable, wbAddr, issue_write, outRdAddr))
          || (inRs2Used && pending(inRs2Addr, scoreboard, wbEnable, wbAddr, issue_write, outRdAddr))
          || (inRdWrite && pending(inRdAddr,  scoreboard, wbEnable, wbAddr, issue_write, outRdAddr));
    inReady = !flush && !hazard && (!outValid || outReady);
    capture = inValid && inReady;
  end

  // Operand resolution with writeback bypass.
  always_comb begin
    op1 = select_operand(inRs1Addr, wbEnable, wbAddr, wbData, rfRs1Data);
    op2 = select_operand(inRs2Addr, wbEnable, wbAddr, wbData, rfRs2Data);
  end

  // Scoreboard update: set is applied after clear so it wins on a shared address.
  always_comb begin
    clr_mask = (wbEnable && (wbAddr != ZERO_ADDR)) ? (ONE_HOT0 << wbAddr) : {REG_NUMBER{1'b0}};
    set_mask = (issue_write && (outRdAddr != ZERO_ADDR)) ? (ONE_HOT0 << outRdAddr)
                                                         : {REG_NUMBER{1'b0}};
    sb_next  = flush ? {REG_NUMBER{1'b0}} : (((scoreboard & ~clr_mask) | set_mask) & ~ONE_HOT0);
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scoreboard <= {REG_NUMBER{1'b0}};
    end else begin
      scoreboard <= sb_next;
    end
  end

  // Output holding register: flush kills, capture loads, issue alone empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid   <= 1'b0;
      outRs1Data <= {DATA_WIDTH{1'b0}};
      outRs2Data <= {DATA_WIDTH{1'b0}};
      outRdAddr  <= ZERO_ADDR;
      outRdWrite <= 1'b0;
      outPayload <= {PAYLOAD_WIDTH{1'b0}};
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (capture) begin
      outValid   <= 1'b1;
      outRs1Data <= op1;
      outRs2Data <= op2;
      outRdAddr  <= inRdAddr;
      outRdWrite <= inRdWrite;
      outPayload <= inPayload;
    end else if (issue) begin
      outValid <= 1'b0;
    end else begin
      outValid <= outValid;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed, table-driven bench for operand_fetch_stage with hand-computed expectations.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inReady, inRs1Used, inRs2Used, inRdWrite;
  logic [4:0]  inRs1Addr, inRs2Addr, inRdAddr, rfRs1Addr, rfRs2Addr, wbAddr, outRdAddr;
  logic [63:0] inPayload, outPayload;
  logic [31:0] rfRs1Data, rfRs2Data, wbData, outRs1Data, outRs2Data;
  logic        wbEnable, outValid, outReady, outRdWrite, flush;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .inRs1Addr(inRs1Addr), .inRs2Addr(inRs2Addr), .inRs1Used(inRs1Used), .inRs2Used(inRs2Used),
    .inRdAddr(inRdAddr), .inRdWrite(inRdWrite), .inPayload(inPayload),
    .rfRs1Addr(rfRs1Addr), .rfRs2Addr(rfRs2Addr), .rfRs1Data(rfRs1Data), .rfRs2Data(rfRs2Data),
    .wbEnable(wbEnable), .wbAddr(wbAddr), .wbData(wbData),
    .outValid(outValid), .outReady(outReady), .outRs1Data(outRs1Data), .outRs2Data(outRs2Data),
    .outRdAddr(outRdAddr), .outRdWrite(outRdWrite), .outPayload(outPayload), .flush(flush)
  );

  logic [31:0] sb_probe;
  assign sb_probe = dut.scoreboard;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] pl;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [63:0] e_pl;
  } vec_t;

  function automatic vec_t mk(
    input logic iv, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd, input logic rw, input logic [63:0] pl,
    input logic [31:0] rf1, input logic [31:0] rf2,
    input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
    input logic ordy, input logic fl, input logic e_ir, input logic e_ov,
    input logic [31:0] e_op1, input logic [31:0] e_op2, input logic [4:0] e_rd,
    input logic e_rw, input logic [63:0] e_pl);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.rw = rw; v.pl = pl;
    v.rf1 = rf1; v.rf2 = rf2; v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_rd = e_rd;
    v.e_rw = e_rw; v.e_pl = e_pl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector right after a posedge, check inReady mid-cycle, then outputs after the edge.
  task automatic apply(input vec_t v, input string name);
    inValid = v.iv; inRs1Addr = v.rs1; inRs1Used = v.u1; inRs2Addr = v.rs2; inRs2Used = v.u2;
    inRdAddr = v.rd; inRdWrite = v.rw; inPayload = v.pl; rfRs1Data = v.rf1; rfRs2Data = v.rf2;
    wbEnable = v.wbe; wbAddr = v.wba; wbData = v.wbd; outReady = v.ordy; flush = v.fl;
    @(negedge clk);
    chk({name, ".inReady"}, {63'd0, inReady}, {63'd0, v.e_ir});
    chk({name, ".rfRs1Addr"}, {59'd0, rfRs1Addr}, {59'd0, v.rs1});
    @(posedge clk);
    #1;
    chk({name, ".outValid"}, {63'd0, outValid}, {63'd0, v.e_ov});
    if (v.e_ov) begin
      chk({name, ".op1"}, {32'd0, outRs1Data}, {32'd0, v.e_op1});
      chk({name, ".op2"}, {32'd0, outRs2Data}, {32'd0, v.e_op2});
      chk({name, ".rd"}, {59'd0, outRdAddr}, {59'd0, v.e_rd});
      chk({name, ".rdw"}, {63'd0, outRdWrite}, {63'd0, v.e_rw});
      chk({name, ".payload"}, outPayload, v.e_pl);
    end
  endtask

  vec_t tbl[8];
  vec_t bp_hold, bp_go;

  initial begin
    rst = 1'b0;
    inValid = 1'b0; inRs1Addr = 5'd0; inRs2Addr = 5'd0; inRs1Used = 1'b0; inRs2Used = 1'b0;
    inRdAddr = 5'd0; inRdWrite = 1'b0; inPayload = 64'd0; rfRs1Data = 32'd0; rfRs2Data = 32'd0;
    wbEnable = 1'b0; wbAddr = 5'd0; wbData = 32'd0; outReady = 1'b0; flush = 1'b0;

    //        iv rs1 u1 rs2 u2 rd rw payload  rf1     rf2     wbe wba wbd  ordy fl  ir ov op1 op2 rd rw pl
    tbl[0] = mk(1, 1, 1, 2, 1, 5, 1, 64'hA1, 32'h11, 32'h22, 0, 0, 32'h0, 0, 0, 1, 1, 32'h11, 32'h22, 5, 1, 64'hA1);
    tbl[1] = mk(1, 5, 1, 0, 0, 6, 1, 64'hA3, 32'h55, 32'h99, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 64'h0);
    tbl[2] = mk(1, 5, 1, 0, 0, 6, 1, 64'hA3, 32'h55, 32'h99, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 64'h0);
    tbl[3] = mk(1, 5, 1, 0, 0, 6, 1, 64'hA3, 32'h55, 32'h99, 1, 5, 32'hDEAD, 1, 0, 1, 1, 32'hDEAD, 32'h0, 6, 1, 64'hA3);
    tbl[4] = mk(1, 0, 1, 0, 1, 0, 1, 64'hA4, 32'h1234, 32'h5678, 1, 0, 32'hFFFF, 1, 0, 1, 1, 32'h0, 32'h0, 0, 1, 64'hA4);
    tbl[5] = mk(1, 6, 1, 3, 1, 7, 1, 64'hA5, 32'h66, 32'h33, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 64'h0);
    tbl[6] = mk(1, 3, 1, 4, 1, 6, 1, 64'hA6, 32'h33, 32'h44, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 64'h0);
    tbl[7] = mk(1, 3, 1, 4, 1, 8, 1, 64'hA7, 32'h33, 32'h44, 1, 3, 32'h333, 1, 0, 1, 1, 32'h333, 32'h44, 8, 1, 64'hA7);

    repeat (2) @(posedge clk);
    #1;
    chk("reset.outValid", {63'd0, outValid}, 64'd0);
    chk("reset.op1", {32'd0, outRs1Data}, 64'd0);
    chk("reset.payload", outPayload, 64'd0);
    chk("reset.sb", {32'd0, sb_probe}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      if (i == 1) chk("vec1.sb", {32'd0, sb_probe}, 64'h20);
      if (i == 4) chk("vec4.sb", {32'd0, sb_probe}, 64'h40);
    end
    chk("vec7.sb", {32'd0, sb_probe}, 64'h40);

    // Backpressure: held outputs stay put, then issue and capture together.
    bp_hold = mk(1, 1, 1, 0, 0, 9, 1, 64'hB0, 32'h111, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h333, 32'h44, 8, 1, 64'hA7);
    bp_go   = mk(1, 1, 1, 0, 0, 9, 1, 64'hB0, 32'h111, 32'h0, 0, 0, 32'h0, 1, 0, 1, 1, 32'h111, 32'h0, 9, 1, 64'hB0);
    for (int i = 0; i < 3; i++) apply(bp_hold, $sformatf("bp_hold%0d", i));
    apply(bp_go, "bp_go");
    chk("bp_go.sb", {32'd0, sb_probe}, 64'h140);

    // Flush with x7 pending, then a read of x7 goes straight through.
    apply(mk(1, 2, 1, 0, 0, 7, 1, 64'hB1, 32'h222, 32'h0, 0, 0, 32'h0, 1, 0, 1, 1, 32'h222, 32'h0, 7, 1, 64'hB1), "c1");
    apply(mk(1, 0, 0, 0, 0, 10, 1, 64'hB2, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 1, 1, 32'h0, 32'h0, 10, 1, 64'hB2), "c2");
    chk("c2.sb", {32'd0, sb_probe}, 64'h3C0);
    apply(mk(1, 7, 1, 0, 0, 0, 0, 64'hB3, 32'h777, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 64'h0), "flush");
    chk("flush.sb", {32'd0, sb_probe}, 64'h0);
    apply(mk(1, 7, 1, 0, 0, 0, 0, 64'hB3, 32'h777, 32'h0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h777, 32'h0, 0, 0, 64'hB3), "post_flush");

    // Reset mid-stream with a valid instruction held and x11 pending.
    apply(mk(1, 0, 0, 0, 0, 11, 1, 64'hB4, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 1, 1, 32'h0, 32'h0, 11, 1, 64'hB4), "r1");
    apply(mk(1, 0, 0, 0, 0, 12, 1, 64'hB5, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 1, 1, 32'h0, 32'h0, 12, 1, 64'hB5), "r2");
    chk("r2.sb", {32'd0, sb_probe}, 64'h800);
    inValid = 1'b0;
    outReady = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.outValid", {63'd0, outValid}, 64'd0);
    chk("async_rst.rd", {59'd0, outRdAddr}, 64'd0);
    chk("async_rst.payload", outPayload, 64'd0);
    chk("async_rst.sb", {32'd0, sb_probe}, 64'd0);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
